// File: rtl/mem_read_stage.sv
// Memory-read front end: issues a word-aligned read, waits MEM_LATENCY cycles, captures and
// lane-shifts the loaded word, and holds it under a valid/ready handshake.
module mem_read_stage #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_op,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic        mdr_valid,
    input  logic        mdr_ready,
    output logic [31:0] mdr_data,
    output logic [1:0]  mdr_op,
    output logic        misalign,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRead, StHold} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       mop_q, mop_d;
    logic             mis_q, mis_d;
    logic             req_misalign;

    // Reserved op 3 is treated as misaligned so it never reaches memory.
    always_comb begin
        unique case (req_op)
            2'd0:    req_misalign = (req_addr[1:0] != 2'b00);
            2'd1:    req_misalign = req_addr[0];
            2'd2:    req_misalign = 1'b0;
            default: req_misalign = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mop_d   = mop_q;
        mis_d   = mis_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    off_d  = req_addr[1:0];
                    op_d   = req_op;
                    addr_d = {req_addr[31:2], 2'b00};
                    if (req_misalign) begin
                        state_d = StHold;
                        data_d  = '0;
                        mis_d   = 1'b1;
                        mop_d   = req_op;
                    end else begin
                        state_d = StRead;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            StRead: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MEM_LATENCY)) begin
                    // Little-endian: addressed lane moves to bit 0, upper bits zero-filled.
                    data_d  = mem_rdata >> {off_q, 3'b000};
                    mop_d   = op_q;
                    mis_d   = 1'b0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (mdr_ready) begin
                    mis_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            off_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mop_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mop_q   <= mop_d;
            mis_q   <= mis_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign mem_rd    = (state_q == StRead);
    assign mdr_valid = (state_q == StHold);
    assign mem_addr  = addr_q;
    assign mdr_data  = data_q;
    assign mdr_op    = mop_q;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_mem_read_stage.sv
// Directed bench for mem_read_stage: three instances (latency 1, 3, 4) share stimulus; each
// scenario checks the instance whose latency it targets.
module tb_mem_read_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_op = '0;
    logic [31:0] mem_rdata = '0;
    logic        mdr_ready = 1'b0;

    logic        req_ready_w [3];
    logic [31:0] mem_addr_w  [3];
    logic        mem_rd_w    [3];
    logic        mdr_valid_w [3];
    logic [31:0] mdr_data_w  [3];
    logic [1:0]  mdr_op_w    [3];
    logic        misalign_w  [3];
    logic        busy_w      [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        mem_read_stage #(.MEM_LATENCY(Lat), .CNT_W(4)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid),
            .req_ready (req_ready_w[g]),
            .req_addr  (req_addr),
            .req_op    (req_op),
            .mem_addr  (mem_addr_w[g]),
            .mem_rd    (mem_rd_w[g]),
            .mem_rdata (mem_rdata),
            .mdr_valid (mdr_valid_w[g]),
            .mdr_ready (mdr_ready),
            .mdr_data  (mdr_data_w[g]),
            .mdr_op    (mdr_op_w[g]),
            .misalign  (misalign_w[g]),
            .busy      (busy_w[g])
        );
    end

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  op;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input int d, input string tag);
        check({tag, " mem_rd"},    32'(mem_rd_w[d]), 32'd0);
        check({tag, " mdr_valid"}, 32'(mdr_valid_w[d]), 32'd0);
        check({tag, " misalign"},  32'(misalign_w[d]), 32'd0);
        check({tag, " busy"},      32'(busy_w[d]), 32'd0);
        check({tag, " mem_addr"},  mem_addr_w[d], 32'd0);
        check({tag, " mdr_data"},  mdr_data_w[d], 32'd0);
        check({tag, " mdr_op"},    32'(mdr_op_w[d]), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        mdr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One request with mdr_ready high throughout; checks latency, read strobe length and result.
    task automatic run_txn(input int d, input int lat, input logic [31:0] addr,
                           input logic [1:0] op, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input logic exp_mis, input string tag);
        int edges;
        int rd_cycles;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_op    = op;
        mem_rdata = rdata;
        mdr_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        edges = 1;
        rd_cycles = 0;
        while (!mdr_valid_w[d] && edges < 40) begin
            if (mem_rd_w[d]) rd_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, " latency"},   32'(edges), exp_mis ? 32'd1 : 32'(lat + 1));
        check({tag, " rd_cycles"}, 32'(rd_cycles), exp_mis ? 32'd0 : 32'(lat));
        check({tag, " mem_addr"},  mem_addr_w[d], {addr[31:2], 2'b00});
        check({tag, " mdr_data"},  mdr_data_w[d], exp_data);
        check({tag, " mdr_op"},    32'(mdr_op_w[d]), 32'(op));
        check({tag, " misalign"},  32'(misalign_w[d]), 32'(exp_mis));
        check({tag, " mem_rd_off"}, 32'(mem_rd_w[d]), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " hs_valid"},  32'(mdr_valid_w[d]), 32'd0);
        check({tag, " hs_ready"},  32'(req_ready_w[d]), 32'd1);
        check({tag, " hs_keep"},   mdr_data_w[d], exp_data);
        mdr_ready = 1'b0;
    endtask

    initial begin
        int edges;
        logic saw_valid;

        vecs[0] = '{32'h0000_0104, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{32'h0000_0203, 2'd2, 32'h1122_3344, 32'h0000_0011, 1'b0};
        vecs[2] = '{32'h0000_0202, 2'd1, 32'h1122_3344, 32'h0000_1122, 1'b0};
        vecs[3] = '{32'h0000_0101, 2'd0, 32'h1122_3344, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h0000_0103, 2'd1, 32'h1122_3344, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_0100, 2'd3, 32'h1122_3344, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h0000_0201, 2'd2, 32'h1122_3344, 32'h0011_2233, 1'b0};
        vecs[7] = '{32'h0000_0100, 2'd1, 32'h1122_3344, 32'h1122_3344, 1'b0};

        #2;
        check_zero_outputs(0, "por");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("por req_ready", 32'(req_ready_w[0]), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_txn(0, 1, vecs[i].addr, vecs[i].op, vecs[i].rdata, vecs[i].exp_data,
                    vecs[i].exp_mis, $sformatf("vec%0d", i));
        end

        // Mid-cycle reset while holding a result: everything clears without a clock edge.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0208;
        req_op    = 2'd0;
        mem_rdata = 32'hA5A5_A5A5;
        mdr_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst valid", 32'(mdr_valid_w[0]), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_zero_outputs(0, "midrst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst req_ready", 32'(req_ready_w[0]), 32'd1);

        // Backpressure on the latency-3 instance with a second request held throughout.
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0104;
        req_op    = 2'd0;
        mem_rdata = 32'hCAFE_F00D;
        mdr_ready = 1'b0;
        @(posedge clk);
        #1;
        req_addr = 32'h0000_0302;
        req_op   = 2'd1;
        edges = 1;
        while (!mdr_valid_w[1] && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("bp latency", 32'(edges), 32'd4);
        check("bp data", mdr_data_w[1], 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d valid", i), 32'(mdr_valid_w[1]), 32'd1);
            check($sformatf("bp hold%0d ready", i), 32'(req_ready_w[1]), 32'd0);
            check($sformatf("bp hold%0d data", i), mdr_data_w[1], 32'hCAFE_F00D);
        end
        check("bp addr held", mem_addr_w[1], 32'h0000_0104);
        mdr_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp hs valid", 32'(mdr_valid_w[1]), 32'd0);
        check("bp hs req_ready", 32'(req_ready_w[1]), 32'd1);
        check("bp hs addr", mem_addr_w[1], 32'h0000_0104);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp 2nd busy", 32'(busy_w[1]), 32'd1);
        check("bp 2nd addr", mem_addr_w[1], 32'h0000_0300);
        edges = 1;
        while (!mdr_valid_w[1] && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("bp 2nd latency", 32'(edges), 32'd4);
        check("bp 2nd data", mdr_data_w[1], 32'h0000_CAFE);
        check("bp 2nd op", 32'(mdr_op_w[1]), 32'd1);
        @(posedge clk);
        #1;
        mdr_ready = 1'b0;

        // Reset during the second READ cycle of the latency-4 instance.
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0400;
        req_op    = 2'd0;
        mem_rdata = 32'h1234_5678;
        mdr_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rdrst rd1", 32'(mem_rd_w[2]), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rdrst mem_rd", 32'(mem_rd_w[2]), 32'd0);
        check("rdrst busy", 32'(busy_w[2]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (mdr_valid_w[2]) saw_valid = 1'b1;
        end
        check("rdrst no valid", 32'(saw_valid), 32'd0);
        run_txn(2, 4, 32'h0000_0404, 2'd0, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, "rdrst next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_read_stage.md
Name: mem_read_stage

Overview:
- Memory-read front end feeding the load-extension unit of the multicycle datapath.
- Accepts a load request (address plus load width), drives a word-aligned read to data memory, and waits a fixed number of cycles for the data.
- Captures the word into its memory data register, shifts the addressed byte or halfword down to bit 0, and holds the result with a valid/ready handshake.
- Detects misaligned accesses and flags them without touching memory.

Parameters:
- MEM_LATENCY, 1, number of cycles mem_rd is held before mem_rdata is sampled; legal range 1..15.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  stage can accept a request.
- req_addr  in  32  byte address of the load.
- req_op  in  2  load width: 0 = word, 1 = half, 2 = byte, 3 = reserved. Same encoding as LoadOp.
- mem_addr  out  32  word-aligned memory address, {addr[31:2], 2'b00}.
- mem_rd  out  1  memory read strobe.
- mem_rdata  in  32  memory read data.
- mdr_valid  out  1  mdr_data, mdr_op and misalign are valid.
- mdr_ready  in  1  downstream consumes the result.
- mdr_data  out  32  lane-aligned load data.
- mdr_op  out  2  req_op of the held request; drives LoadOp downstream.
- misalign  out  1  held request was misaligned or reserved; qualified by mdr_valid.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset:
  - Asynchronous; all outputs and registers clear at once: mem_rd, mdr_valid, misalign, busy = 0; mem_addr, mdr_data, mdr_op = 0; counter = 0; state = IDLE.
  - Reset mid-operation aborts the request. mem_rd drops with reset and any in-flight mem_rdata is discarded.
- States and transitions:
  - IDLE: req_ready = 1. Acceptance occurs on an edge where req_valid = 1. At that edge the stage latches req_addr[1:0] and req_op into internal registers, and loads mem_addr with the aligned address.
  - IDLE, aligned request: next state READ. mem_rd = 1 and counter = 1.
  - IDLE, misaligned request: next state HOLD. mem_rd stays 0, mdr_data = 0, misalign = 1, mdr_op = req_op.
  - READ: mem_rd = 1 and mem_addr stays stable. Each edge increments the counter. On the edge where counter == MEM_LATENCY:
    - mdr_data <= mem_rdata >> (8 * offset), zero-filled, where offset = latched addr[1:0];
    - mdr_op <= latched op; misalign <= 0; mem_rd <= 0; state <= HOLD.
  - HOLD: mdr_valid = 1 and all mdr_* outputs stay stable. On an edge where mdr_ready = 1: mdr_valid <= 0, misalign <= 0, state <= IDLE. mdr_data keeps its value after the handshake.
- Misalignment rule:
  - op 0 with addr[1:0] != 0;
  - op 1 with addr[0] = 1;
  - op 3 with any address.
- Lane rule: little-endian. Byte at offset b occupies mem_rdata[8b+7:8b]. The shift moves it to bits [7:0]; a half at offset 2 moves to bits [15:0]. Upper bits after the shift are not cleared beyond zero-fill; the load-extension stage masks them.
- Latency:
  - Aligned request: mdr_valid rises MEM_LATENCY + 1 edges after the accepting edge.
  - Misaligned request: mdr_valid rises 1 edge after the accepting edge.
- Throughput: at most one request per MEM_LATENCY + 2 cycles. req_ready = 0 in READ and HOLD, so requests arriving then are not accepted and the requester must hold req_valid.
- Handshake timing:
  - req_valid is ignored outside IDLE.
  - An mdr_ready already high on the cycle mdr_valid rises completes the handshake on the next edge.
  - mdr_ready in IDLE or READ has no effect.
- No combinational path from any input to any output. All outputs are registered or decoded from state.

Test Plan:
- Reset then idle, MEM_LATENCY = 1:
  - reset pulse in mid-cycle -> all outputs 0 immediately, req_ready = 1 after release.
- Aligned word, MEM_LATENCY = 1:
  - stimulus: addr 0x0000_0104, op 0, mem_rdata 0xDEADBEEF, mdr_ready = 1.
  - response: mem_addr 0x104, mem_rd high exactly 1 cycle, mdr_valid 2 edges after accept for 1 cycle, mdr_data 0xDEADBEEF, mdr_op 0, misalign 0.
- Byte and half lanes:
  - stimulus: mem_rdata 0x11223344; byte at 0x203, then half at 0x202.
  - response: mem_addr 0x200 both times; mdr_data 0x00000011 for the byte, 0x00001122 for the half.
- Misaligned and reserved:
  - stimulus: word at 0x101, half at 0x103, op 3 at 0x100.
  - response: mem_rd never asserted, misalign = 1 with mdr_valid one edge after accept, mdr_data 0.
- Backpressure, MEM_LATENCY = 3:
  - stimulus: mdr_ready = 0 for 5 cycles after valid; a second req_valid held throughout.
  - response: mdr_data stable, req_ready = 0, second request accepted only on the edge after the handshake.
- Reset mid-READ, MEM_LATENCY = 4:
  - stimulus: assert reset in the 2nd READ cycle.
  - response: mem_rd = 0 immediately; mdr_valid never rises; the next request after release completes normally.
